// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares one cacheline-wide physical-memory port between the I-cache
//   (read-only) and the D-cache (read/write). One whole line transaction is
//   in flight at a time. The downstream command, address and write data are
//   registered at grant and held until pmem_resp. The response is steered
//   back to the owning cache only.
//
//   Ports:
//     clk, rst                          clock, async active-high reset
//     i_read, i_address                 I-cache line read request
//     i_rdata, i_resp                   I-cache returned line / completion
//     d_read, d_write, d_address,
//     d_wdata                           D-cache line read / writeback request
//     d_rdata, d_resp                   D-cache returned line / completion
//     pmem_read, pmem_write,
//     pmem_address, pmem_wdata          registered downstream command
//     pmem_rdata, pmem_resp             downstream read line / completion
//
//   Optional feature macro: CACHE_ARB_RR_EN
//     defined   : round-robin when both caches request in IDLE
//     undefined : fixed priority, D over I
module cache_arbiter #(
    parameter int s_line = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   last_grant_d, last_grant_d_nx;  // 1: D served last, 0: I served last
    logic   i_req, d_req, grant_d;
    logic   load, clear;

    always_comb begin
        i_req = i_read;
        d_req = d_read | d_write;
`ifdef CACHE_ARB_RR_EN
        // Under contention, the requester not served last wins.
        grant_d = d_req & (~i_req | ~last_grant_d);
`else
        grant_d = d_req;
`endif
        state_nx        = state;
        last_grant_d_nx = last_grant_d;
        load            = 1'b0;
        clear           = 1'b0;
        case (state)
            IDLE: begin
                // pmem_resp is deliberately ignored here (spurious response).
                if (grant_d) begin
                    state_nx = SERVE_D;
                    load     = 1'b1;
                end else if (i_req) begin
                    state_nx = SERVE_I;
                    load     = 1'b1;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_nx        = IDLE;
                    last_grant_d_nx = 1'b0;
                    clear           = 1'b1;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_nx        = IDLE;
                    last_grant_d_nx = 1'b1;
                    clear           = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state        <= state_nx;
            last_grant_d <= last_grant_d_nx;
            if (load) begin
                if (grant_d) begin
                    // Write wins when the D-cache raises both commands.
                    pmem_address <= d_address;
                    pmem_wdata   <= d_wdata;
                    pmem_write   <= d_write;
                    pmem_read    <= ~d_write & d_read;
                end else begin
                    pmem_address <= i_address;
                    pmem_write   <= 1'b0;
                    pmem_read    <= 1'b1;
                end
            end else if (clear) begin
                pmem_read  <= 1'b0;
                pmem_write <= 1'b0;
            end
        end
    end

    // Data is broadcast; only the resp tells a cache the line is its own.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;
    assign i_resp  = (state == SERVE_I) & pmem_resp;
    assign d_resp  = (state == SERVE_D) & pmem_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
    localparam int SL = 256;
    localparam int AW = 32;
    localparam logic [SL-1:0] A5 = {32{8'hA5}};
    localparam logic [SL-1:0] W1 = {8{32'h1234_5678}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read = 0, d_read = 0, d_write = 0, pmem_resp = 0;
    logic [AW-1:0] i_address = '0, d_address = '0;
    logic [SL-1:0] d_wdata = '0, pmem_rdata = '0;
    logic [SL-1:0] i_rdata, d_rdata, pmem_wdata;
    logic          i_resp, d_resp, pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;

    cache_arbiter #(.s_line(SL), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int n_iresp = 0, n_dresp = 0;

    task automatic chk(input string nm, input logic [SL-1:0] act, input logic [SL-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Transaction-level reference: who owns the port, what command it carries.
    int            m_owner = 0;   // 0 none, 1 I, 2 D
    int            m_last  = 2;   // requester completed most recently
    logic          m_rd = 0, m_wr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [SL-1:0] m_wdata = '0;

    task automatic model_reset();
        m_owner = 0; m_last = 2; m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else if (m_owner == 0) begin
            int win;
            bit di, dd;
            di = i_read;
            dd = d_read | d_write;
            win = 0;
            if (di && dd) begin
`ifdef CACHE_ARB_RR_EN
                win = (m_last == 2) ? 1 : 2;
`else
                win = 2;
`endif
            end else if (dd) win = 2;
            else if (di) win = 1;
            if (win == 2) begin
                m_owner = 2; m_addr = d_address; m_wdata = d_wdata;
                m_wr = d_write; m_rd = !d_write && d_read;
            end else if (win == 1) begin
                m_owner = 1; m_addr = i_address; m_rd = 1; m_wr = 0;
            end
        end else if (pmem_resp) begin
            m_last = m_owner; m_owner = 0; m_rd = 0; m_wr = 0;
        end
    end

    always @(negedge clk) begin
        if (rst) model_reset();
        chk("pmem_read", pmem_read, m_rd);
        chk("pmem_write", pmem_write, m_wr);
        if (m_rd || m_wr) chk("pmem_address", pmem_address, m_addr);
        if (m_wr) chk("pmem_wdata", pmem_wdata, m_wdata);
        chk("i_resp", i_resp, (m_owner == 1) && pmem_resp && !rst);
        chk("d_resp", d_resp, (m_owner == 2) && pmem_resp && !rst);
        chk("i_rdata", i_rdata, pmem_rdata);
        chk("d_rdata", d_rdata, pmem_rdata);
        if (i_resp) n_iresp++;
        if (d_resp) n_dresp++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic nck();
        @(negedge clk); #1;
    endtask

    int ci, cd;

    initial begin
        // reset state
        nck();
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_pmem_address", pmem_address, '0);
        chk("rst_pmem_wdata", pmem_wdata, '0);
        chk("rst_i_resp", i_resp, 1'b0);
        chk("rst_d_resp", d_resp, 1'b0);
        tick(); rst = 0;

        // I only: grant one cycle after request
        tick(); ci = n_iresp; cd = n_dresp;
        i_read = 1; i_address = 32'h0000_0040;
        nck(); chk("ionly_no_early_cmd", pmem_read, 1'b0);
        tick(); nck();
        chk("ionly_cmd", pmem_read, 1'b1);
        chk("ionly_addr", pmem_address, 32'h40);
        repeat (3) tick();
        pmem_resp = 1; pmem_rdata = A5;
        nck();
        chk("ionly_iresp", i_resp, 1'b1);
        chk("ionly_rdata", i_rdata, A5);
        chk("ionly_dresp", d_resp, 1'b0);
        tick(); pmem_resp = 0; i_read = 0;
        nck(); chk("ionly_cmd_clear", pmem_read, 1'b0);
        chk("ionly_resp_count", n_iresp - ci, 1);
        chk("ionly_dresp_count", n_dresp - cd, 0);

        // D writeback, source data changes while waiting
        tick(); cd = n_dresp;
        d_write = 1; d_address = 32'h0000_0080; d_wdata = W1;
        tick(); d_wdata = ~W1;
        nck();
        chk("dwb_cmd", pmem_write, 1'b1);
        chk("dwb_no_read", pmem_read, 1'b0);
        chk("dwb_wdata", pmem_wdata, W1);
        tick(); tick(); nck();
        chk("dwb_wdata_hold", pmem_wdata, W1);
        chk("dwb_addr_hold", pmem_address, 32'h80);
        tick(); pmem_resp = 1;
        nck(); chk("dwb_dresp", d_resp, 1'b1);
        tick(); pmem_resp = 0; d_write = 0;
        nck(); chk("dwb_cmd_clear", pmem_write, 1'b0);
        chk("dwb_resp_count", n_dresp - cd, 1);

        // Contention, last_grant = D here
        tick(); ci = n_iresp; cd = n_dresp;
        i_read = 1; i_address = 32'h40; d_read = 1; d_address = 32'h80;
`ifdef CACHE_ARB_RR_EN
        for (int t = 0; t < 4; t++) begin
            tick(); nck();
            chk("rr_grant_addr", pmem_address, (t % 2 == 0) ? 32'h40 : 32'h80);
            tick(); pmem_resp = 1;
            nck();
            chk("rr_iresp", i_resp, (t % 2 == 0) ? 1'b1 : 1'b0);
            chk("rr_dresp", d_resp, (t % 2 == 0) ? 1'b0 : 1'b1);
            tick(); pmem_resp = 0;
        end
        i_read = 0; d_read = 0;
        chk("rr_iresp_count", n_iresp - ci, 2);
        chk("rr_dresp_count", n_dresp - cd, 2);
`else
        tick(); nck();
        chk("prio_d_first", pmem_address, 32'h80);
        tick(); pmem_resp = 1;
        nck();
        chk("prio_dresp", d_resp, 1'b1);
        chk("prio_no_iresp", i_resp, 1'b0);
        tick(); pmem_resp = 0; d_read = 0;
        nck(); chk("prio_idle_gap", pmem_read, 1'b0);
        tick(); nck();
        chk("prio_i_second", pmem_read, 1'b1);
        chk("prio_i_addr", pmem_address, 32'h40);
        tick(); pmem_resp = 1;
        nck(); chk("prio_iresp", i_resp, 1'b1);
        tick(); pmem_resp = 0; i_read = 0;
        chk("prio_iresp_count", n_iresp - ci, 1);
        chk("prio_dresp_count", n_dresp - cd, 1);
`endif

        // Reset two cycles into SERVE_D
        tick(); cd = n_dresp;
        d_write = 1; d_address = 32'h80; d_wdata = W1;
        tick(); tick(); tick();
        rst = 1; #1;
        chk("rst_mid_write_drop", pmem_write, 1'b0);
        chk("rst_mid_dresp", d_resp, 1'b0);
        tick(); rst = 0; d_write = 0;
        tick(); pmem_resp = 1;
        nck();
        chk("rst_mid_late_dresp", d_resp, 1'b0);
        chk("rst_mid_idle", pmem_write, 1'b0);
        tick(); pmem_resp = 0;
        chk("rst_mid_dresp_count", n_dresp - cd, 0);

        // Spurious response in IDLE
        tick(); pmem_resp = 1;
        nck();
        chk("spur_iresp", i_resp, 1'b0);
        chk("spur_dresp", d_resp, 1'b0);
        tick(); pmem_resp = 0;
        nck();
        chk("spur_no_read", pmem_read, 1'b0);
        chk("spur_no_write", pmem_write, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (rst) rst = 0;
            else if ($urandom_range(0, 199) == 0) rst = 1;
            i_read    = ($urandom_range(0, 2) != 0);
            d_read    = ($urandom_range(0, 2) == 0);
            d_write   = ($urandom_range(0, 3) == 0);
            i_address = $urandom() & 32'hFFFF_FFE0;
            d_address = $urandom() & 32'hFFFF_FFE0;
            d_wdata   = {$urandom(), $urandom(), $urandom(), $urandom(),
                         $urandom(), $urandom(), $urandom(), $urandom()};
            pmem_rdata = {$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom(), $urandom()};
            if (pmem_read || pmem_write) pmem_resp = ($urandom_range(0, 2) == 0);
            else pmem_resp = ($urandom_range(0, 15) == 0);
        end
        tick(); rst = 0; pmem_resp = 0; i_read = 0; d_read = 0; d_write = 0;
        nck();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single cacheline-wide physical-memory port between the instruction cache (read-only) and the data cache (read and write).
- Sits between the two cache datapaths' RAM-side interfaces and the cacheline adaptor.
- Serves one whole line transaction at a time.
- Holds downstream address, data and command stable from grant until response, and steers the response back to the owning cache only.

Parameters:
s_line, 256, cacheline width in bits
ADDR_W, 32, address width in bits

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
i_read  input  1  I-cache line read request
i_address  input  ADDR_W  I-cache line address (low offset bits zero)
i_rdata  output  s_line  line returned to I-cache
i_resp  output  1  I-cache transaction complete
d_read  input  1  D-cache line read request
d_write  input  1  D-cache line writeback request
d_address  input  ADDR_W  D-cache line address
d_wdata  input  s_line  D-cache writeback line
d_rdata  output  s_line  line returned to D-cache
d_resp  output  1  D-cache transaction complete
pmem_read  output  1  downstream read command
pmem_write  output  1  downstream write command
pmem_address  output  ADDR_W  downstream address
pmem_wdata  output  s_line  downstream write line
pmem_rdata  input  s_line  downstream read line
pmem_resp  input  1  downstream transaction complete

Behaviour:
- Clocking and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: state=IDLE, last_grant=D, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0. i_resp and d_resp are 0 while in reset.
- States:
  - IDLE: no transaction outstanding.
  - SERVE_I: I-cache read outstanding.
  - SERVE_D: D-cache read or write outstanding.
- IDLE transitions: on a clock edge with a pending request, select a winner and go to SERVE_I or SERVE_D. In the same edge, register pmem_address, pmem_wdata and pmem_read/pmem_write from the winner's inputs.
  - Grant latency: request high in cycle N means the command is high in cycle N+1.
- SERVE_* transitions:
  - Command registers hold their values (stable) until pmem_resp=1.
  - On the edge where pmem_resp=1, clear pmem_read/pmem_write, set last_grant to the served requester, and return to IDLE.
  - There is always at least one IDLE cycle between transactions, so a cache can drop its request after its resp.
- Response steering (combinational):
  - i_resp = pmem_resp when state==SERVE_I, else 0.
  - d_resp = pmem_resp when state==SERVE_D, else 0.
  - i_rdata = d_rdata = pmem_rdata, broadcast; only the resp qualifies the data.
- D-cache command decode: d_write=1 issues a write with pmem_wdata=d_wdata. Otherwise d_read=1 issues a read. d_read and d_write both high: write wins, pmem_read stays 0.
- Arbitration without the optional feature: fixed priority, D over I.
- Requests arriving while in SERVE_* wait; no preemption, no queueing beyond the level-held request.
- pmem_resp in IDLE (spurious): ignored, no requester resp, state unchanged.
- Request dropped mid-transaction: the transaction completes anyway and the resp is still pulsed.
- Reset mid-transaction: commands drop immediately and asynchronously, state=IDLE, no resp is generated. The downstream port tolerates abandoned transactions.

Optional Feature:
CACHE_ARB_RR_EN
- Defined: when both caches request in IDLE, grant the requester that is not last_grant (round-robin). A single requester is granted regardless of last_grant.
- Undefined: fixed D-over-I priority; last_grant is still maintained but does not affect selection.

Test Plan:
- I only: i_read=1, i_address=0x0000_0040; pmem_resp one cycle at 5 cycles, pmem_rdata=0xA5..A5 -> pmem_read=1 from next cycle with pmem_address=0x40; i_resp one cycle, i_rdata=0xA5..A5; d_resp=0; pmem_read=0 after resp.
- D writeback: d_write=1, d_address=0x0000_0080, d_wdata=0x1234..; d_wdata changed while waiting -> pmem_write=1, pmem_wdata stays 0x1234.. until resp; d_resp one cycle; pmem_read never high.
- Contention, macro off: i_read and d_read raised in the same cycle -> D served first, then an IDLE cycle, then I at 0x40; exactly one resp per requester.
- Contention, macro on: after a prior D transaction (last_grant=D), both request -> I served first; with both held continuously, grants alternate I,D,I,D over 4 transactions.
- Reset mid-transaction: rst asserted 2 cycles into SERVE_D, then pmem_resp=1 after release -> pmem_write drops in the reset cycle; d_resp never asserts; state is IDLE.
- Spurious response: pmem_resp=1 in IDLE with no requests -> i_resp=d_resp=0, no command issued.
